// File: rtl/thread_register_file.sv
// Per-thread 16-entry register file for one SIMT lane; R13..R15 hold blockIdx, blockDim and threadIdx.
// Optional REGISTER_FILE_DEBUG_EN adds a combinational debug read port.
module thread_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic [3:0]           decoded_rd_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
`ifdef REGISTER_FILE_DEBUG_EN
    input  logic [3:0]           debug_address,
    output logic [DATA_BITS-1:0] debug_data,
`endif
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    localparam logic [2:0] ST_REQUEST = 3'd3;
    localparam logic [2:0] ST_UPDATE  = 3'd6;

    localparam logic [1:0] MUX_ARITH = 2'd0;
    localparam logic [1:0] MUX_MEM   = 2'd1;
    localparam logic [1:0] MUX_CONST = 2'd2;

    localparam int NUM_GP = 13;

    localparam logic [DATA_BITS-1:0] BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] gp_regs [NUM_GP];
    logic [DATA_BITS-1:0] block_idx;
    logic [DATA_BITS-1:0] reg_view [16];

    logic                 wr_valid;
    logic [DATA_BITS-1:0] wr_data;
    logic                 rd_capture;

    // Flat 16-entry view so reads decode the full 4-bit address with no aliasing.
    always_comb begin
        for (int i = 0; i < NUM_GP; i++) begin
            reg_view[i] = gp_regs[i];
        end
        reg_view[13] = block_idx;
        reg_view[14] = BLOCK_DIM;
        reg_view[15] = THREAD_IDX;
    end

    always_comb begin
        wr_data  = '0;
        wr_valid = 1'b0;
        case (decoded_reg_input_mux)
            MUX_ARITH: wr_data = alu_out;
            MUX_MEM:   wr_data = lsu_out;
            MUX_CONST: wr_data = decoded_immediate;
            default:   wr_data = '0;
        endcase
        if (enable && (core_state == ST_UPDATE) && decoded_reg_write_enable &&
            (decoded_rd_address < 4'(NUM_GP)) && (decoded_reg_input_mux != 2'd3)) begin
            wr_valid = 1'b1;
        end
    end

    assign rd_capture = enable && (core_state == ST_REQUEST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_GP; i++) begin
                if (wr_valid && (decoded_rd_address == 4'(i))) begin
                    gp_regs[i] <= wr_data;
                end
            end
        end
    end

    // blockIdx tracks the dispatcher every cycle, regardless of lane activity.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_idx <= '0;
        end else begin
            block_idx <= block_id;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs <= '0;
            rt <= '0;
        end else if (rd_capture) begin
            rs <= reg_view[decoded_rs_address];
            rt <= reg_view[decoded_rt_address];
        end
    end

`ifdef REGISTER_FILE_DEBUG_EN
    assign debug_data = reg_view[debug_address];
`endif

endmodule

// File: doc/thread_register_file.md
Name: thread_register_file

Overview:
- Per-thread register file for one SIMT lane. Supplies the ALU's two source operands (rs, rt) and absorbs its result (alu_out), the LSU load result, or a decoded immediate.
- One instance per thread per core. Sequenced entirely by the core's 3-bit core_state, the same state vector the ALU sees.
- R13–R15 are read-only special registers: blockIdx, blockDim, threadIdx.

Parameters:
- THREADS_PER_BLOCK, 4, reset/constant value of R14 (blockDim); must fit in DATA_BITS.
- THREAD_ID, 0, constant value of R15 (threadIdx); must be < THREADS_PER_BLOCK.
- DATA_BITS, 8, register and operand width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- enable  in  1  lane active; when 0, no read capture and no write
- block_id  in  DATA_BITS  current block index from dispatcher
- core_state  in  3  IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7
- decoded_rs_address  in  4  source register 1 index
- decoded_rt_address  in  4  source register 2 index
- decoded_rd_address  in  4  destination register index
- decoded_reg_write_enable  in  1  instruction writes rd
- decoded_reg_input_mux  in  2  0=arithmetic (alu_out), 1=memory (lsu_out), 2=constant (decoded_immediate), 3=reserved
- decoded_immediate  in  DATA_BITS  constant for CONST instructions
- alu_out  in  DATA_BITS  ALU result
- lsu_out  in  DATA_BITS  LSU load data
- rs  out  DATA_BITS  registered operand 1 to ALU/LSU
- rt  out  DATA_BITS  registered operand 2 to ALU/LSU

Behaviour:
- Storage is 16 x DATA_BITS.
- Reset (reset=0, async, takes effect immediately, including mid-instruction):
  - R0–R12 = 0; R13 = 0; R14 = THREADS_PER_BLOCK; R15 = THREAD_ID.
  - rs = 0, rt = 0.
  - Any in-flight read or write is discarded.
- R13 update: on every rising edge out of reset, R13 <= block_id, independent of enable and core_state.
- Read capture:
  - On a rising edge with enable=1 and core_state==REQUEST: rs <= R[decoded_rs_address], rt <= R[decoded_rt_address].
  - Latency is one edge. Values are valid from the cycle after REQUEST (WAIT/EXECUTE) and held until the next qualifying REQUEST edge.
  - Reading R13 returns the value captured on the previous edge.
- Write:
  - On a rising edge with enable=1, core_state==UPDATE, decoded_reg_write_enable=1 and decoded_rd_address < 13: R[rd] <= the source selected by decoded_reg_input_mux.
  - Writes are suppressed (storage unchanged, no error) for: rd in 13..15, mux=3, and enable=0.
- Reads and writes never share a state, so no read/write bypass is required. A write in UPDATE is visible at the next instruction's REQUEST.
- Repeated UPDATE cycles rewrite the same value; this is idempotent.
- Values are stored verbatim, with no truncation beyond DATA_BITS. Address decode is full 4-bit; there is no aliasing.
- Any core_state other than REQUEST or UPDATE leaves rs, rt and R0–R12 unchanged.

Optional Feature:
- Macro: REGISTER_FILE_DEBUG_EN.
- Defined:
  - Adds input debug_address[3:0] and output debug_data[DATA_BITS-1:0].
  - debug_data = R[debug_address], combinational, with zero cycles of latency.
  - debug_data reflects writes on the edge after they occur and reads 0 during reset (R14/R15 read their constants).
  - No effect on rs/rt timing.
- Undefined: both ports and the read mux are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then REQUEST with rs=14, rt=15 (THREADS_PER_BLOCK=4, THREAD_ID=2) -> rs=4, rt=2 the cycle after REQUEST.
- UPDATE, mux=0, rd=3, alu_out=0x5A, write_en=1; then REQUEST with rs=3 -> rs=0x5A. Repeat with mux=1, lsu_out=0xC3 on rd=4 -> 0xC3. Repeat with mux=2, immediate=0x7F on rd=12 -> 0x7F.
- UPDATE with rd=13, 14, 15 and alu_out=0xFF -> subsequent reads return block_id, 4 and THREAD_ID unchanged. Also: mux=3 write to rd=5 -> R5 stays 0.
- enable=0 through REQUEST and UPDATE with valid write to rd=1 -> rs/rt hold prior values and R1 unchanged.
- block_id=0x09 for two cycles, then REQUEST with rs=13 -> rs=0x09.
- After writing R2=0x11 and capturing rs=0x11, drive reset low mid-EXECUTE -> rs=rt=0 immediately (before the next edge); post-reset read of R2 -> 0.
